// File: rtl/ram_dp_pipe.sv
// Simple dual-port RAM with byte-enable writes, a 1..3 stage read pipeline,
// selectable read/write collision behaviour and out-of-range address flags.
module ram_dp_pipe #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DEPTH        = 48,
  parameter int unsigned RD_LATENCY   = 1,
  parameter bit          WRITE_FIRST  = 1'b0,
  parameter bit          CLEAR_ON_RST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_enb,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_enb,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_err,
  output logic                    wr_err
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  collide;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [RD_LATENCY-1:0] vld_q;
  logic [RD_LATENCY-1:0] err_q;
  logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];
  logic                  wr_err_q;

  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < DepthLim);
    rd_in_range = ({1'b0, rd_addr} < DepthLim);
    collide     = wr_enb && wr_in_range && (wr_addr == rd_addr);
    old_word    = '0;
    if (rd_in_range) begin
      old_word = mem[rd_addr];
    end
    // Merged word is what the addressed location will hold after this edge.
    merged_word = old_word;
    for (int b = 0; b < NumBytes; b++) begin
      if (collide && wr_be[b]) begin
        merged_word[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
    rd_word = WRITE_FIRST ? merged_word : old_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RST) begin
        for (int w = 0; w < DEPTH; w++) begin
          mem[w] <= '0;
        end
      end
    end else if (wr_enb && wr_in_range) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (wr_be[b]) begin
          mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Data stages only load on a valid entry so rd_data holds between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      err_q    <= '0;
      wr_err_q <= 1'b0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        dat_q[s] <= '0;
      end
    end else begin
      wr_err_q <= wr_enb && !wr_in_range;
      vld_q[0] <= rd_enb;
      err_q[0] <= rd_enb && !rd_in_range;
      if (rd_enb) begin
        dat_q[0] <= rd_word;
      end
      for (int s = 1; s < RD_LATENCY; s++) begin
        vld_q[s] <= vld_q[s-1];
        err_q[s] <= err_q[s-1];
        if (vld_q[s-1]) begin
          dat_q[s] <= dat_q[s-1];
        end
      end
    end
  end

  assign rd_data  = dat_q[RD_LATENCY-1];
  assign rd_valid = vld_q[RD_LATENCY-1];
  assign rd_err   = err_q[RD_LATENCY-1];
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_ram_dp_pipe.sv
// Bench for ram_dp_pipe: two instances (A: latency 1, read-first, clear on reset;
// B: latency 3, write-first, keep on reset) driven identically, checked by scoreboards.
module tb_ram_dp_pipe;

  localparam int unsigned LatA = 1;
  localparam int unsigned LatB = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_enb;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_enb;
  logic [5:0]  rd_addr;

  logic [31:0] a_rd_data, b_rd_data;
  logic        a_rd_valid, b_rd_valid;
  logic        a_rd_err, b_rd_err;
  logic        a_wr_err, b_wr_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_dp_pipe #(
    .DATA_WIDTH(32), .ADDR_WIDTH(6), .DEPTH(48), .RD_LATENCY(LatA),
    .WRITE_FIRST(1'b0), .CLEAR_ON_RST(1'b1)
  ) u_a (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .rd_err(a_rd_err), .wr_err(a_wr_err)
  );

  ram_dp_pipe #(
    .DATA_WIDTH(32), .ADDR_WIDTH(6), .DEPTH(48), .RD_LATENCY(LatB),
    .WRITE_FIRST(1'b1), .CLEAR_ON_RST(1'b0)
  ) u_b (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .rd_err(b_rd_err), .wr_err(b_wr_err)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  task automatic chk_rd(input string nm, input logic [31:0] d, input logic e, input exp_t x);
    checks++;
    if (d !== x.data || e !== x.err || cyc != x.due) begin
      failures++;
      $display("FAIL %s got data=%h err=%b cycle=%0d expected data=%h err=%b cycle=%0d",
               nm, d, e, cyc, x.data, x.err, x.due);
    end
  endtask

  // Scoreboard monitors: pop one expectation per rd_valid pulse.
  always @(negedge clk) begin
    if (a_rd_valid) begin
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_rd unexpected rd_valid data=%h at cycle %0d", a_rd_data, cyc);
      end else begin
        chk_rd("a_rd", a_rd_data, a_rd_err, qa.pop_front());
      end
    end else if (a_rd_err !== 1'b0) begin
      chk("a_rd_err_idle", {31'b0, a_rd_err}, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (b_rd_valid) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_rd unexpected rd_valid data=%h at cycle %0d", b_rd_data, cyc);
      end else begin
        chk_rd("b_rd", b_rd_data, b_rd_err, qb.pop_front());
      end
    end else if (b_rd_err !== 1'b0) begin
      chk("b_rd_err_idle", {31'b0, b_rd_err}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    wr_enb = 1'b0;
    rd_enb = 1'b0;
    wr_be  = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic set_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_enb  = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_be   = be;
  endtask

  task automatic set_rd(input logic [5:0] a, input logic [31:0] da, input logic ea,
                        input logic [31:0] db, input logic eb, input bit push_b = 1'b1);
    exp_t x;
    rd_enb  = 1'b1;
    rd_addr = a;
    x.data = da; x.err = ea; x.due = cyc + LatA;
    qa.push_back(x);
    if (push_b) begin
      x.data = db; x.err = eb; x.due = cyc + LatB;
      qb.push_back(x);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_rd_data"},  a_rd_data, 32'd0);
    chk({tag, "_a_flags"},    {29'b0, a_rd_valid, a_rd_err, a_wr_err}, 32'd0);
    chk({tag, "_b_rd_data"},  b_rd_data, 32'd0);
    chk({tag, "_b_flags"},    {29'b0, b_rd_valid, b_rd_err, b_wr_err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; wr_enb = 1'b0; rd_enb = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    idle(2);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Reset clears A but B keeps its contents.
    set_wr(6'd5, 32'hDEADBEEF, 4'hF); step();
    set_rd(6'd5, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0); step();
    idle(4);
    rst = 1'b1; step(); rst = 1'b0;
    chk_reset_outputs("reset2");
    set_rd(6'd5, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0); step();
    idle(4);

    // Byte-enable merge.
    set_wr(6'd3, 32'h11223344, 4'hF); step();
    set_wr(6'd3, 32'hAABBCCDD, 4'b0101); step();
    set_rd(6'd3, 32'h11BB33DD, 1'b0, 32'h11BB33DD, 1'b0); step();

    // Collisions: A returns old word, B the merged word.
    set_wr(6'd7, 32'h12345678, 4'hF); step();
    set_wr(6'd7, 32'hCAFEF00D, 4'hF);
    set_rd(6'd7, 32'h12345678, 1'b0, 32'hCAFEF00D, 1'b0); step();
    set_rd(6'd7, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0); step();
    set_wr(6'd7, 32'h99887766, 4'b0011);
    set_rd(6'd7, 32'hCAFEF00D, 1'b0, 32'hCAFE7766, 1'b0); step();
    set_rd(6'd7, 32'hCAFE7766, 1'b0, 32'hCAFE7766, 1'b0); step();

    // Back-to-back reads @0..@9.
    for (int i = 0; i < 10; i++) begin
      set_wr(6'(i), 32'h100 + 32'(i), 4'hF); step();
    end
    for (int i = 0; i < 10; i++) begin
      set_rd(6'(i), 32'h100 + 32'(i), 1'b0, 32'h100 + 32'(i), 1'b0); step();
    end
    idle(4);

    // Address range boundaries and the wr_be=0 no-op.
    set_wr(6'd2, 32'h0202A5A5, 4'hF); step();
    set_wr(6'd47, 32'h47474747, 4'hF); step();
    chk("wr_err_in_range_a", {31'b0, a_wr_err}, 32'd0);
    chk("wr_err_in_range_b", {31'b0, b_wr_err}, 32'd0);
    set_wr(6'd50, 32'hBAD0BAD0, 4'hF); step();
    chk("wr_err_oor_a", {31'b0, a_wr_err}, 32'd1);
    chk("wr_err_oor_b", {31'b0, b_wr_err}, 32'd1);
    set_wr(6'd2, 32'hFFFFFFFF, 4'h0); step();
    chk("wr_err_pulse_a", {31'b0, a_wr_err}, 32'd0);
    chk("wr_err_pulse_b", {31'b0, b_wr_err}, 32'd0);
    set_rd(6'd50, 32'h0, 1'b1, 32'h0, 1'b1); step();
    set_rd(6'd2, 32'h0202A5A5, 1'b0, 32'h0202A5A5, 1'b0); step();
    set_rd(6'd47, 32'h47474747, 1'b0, 32'h47474747, 1'b0); step();
    set_rd(6'd48, 32'h0, 1'b1, 32'h0, 1'b1); step();
    idle(4);

    // Reset with two reads in flight on B; A has already returned them.
    set_wr(6'd20, 32'h55AA55AA, 4'hF); step();
    set_rd(6'd20, 32'h55AA55AA, 1'b0, 32'h0, 1'b0, 1'b0); step();
    set_rd(6'd20, 32'h55AA55AA, 1'b0, 32'h0, 1'b0, 1'b0); step();
    rst = 1'b1; step(); step(); rst = 1'b0;
    set_rd(6'd20, 32'h0, 1'b0, 32'h55AA55AA, 1'b0); step();

    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) step();
    idle(3);
    chk("drain_a", 32'(qa.size()), 32'd0);
    chk("drain_b", 32'(qb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
